puf_chal_sched: RTL and testbench

Challenge scheduler that drives the read-write-collision generator (`rwc_ctrl`). It walks a programmable number of challenges, with addresses incrementing from a base and data from a 32-bit LFSR. Each challenge is applied `REPEATS` times, and the per-bit majority response plus a stability mask is emitted on a valid/ready stream. It replaces the single hard-coded challenge loop in the top-level controller and sits between that top and `rwc_ctrl`.

---
 rtl/puf_pkg.sv | 11 +
 rtl/puf_chal_sched_if.sv | 9 +
 rtl/puf_vote_acc.sv | 29 ++
 rtl/puf_chal_sched.sv | 145 ++++++++++++++
 tb/tb_puf_chal_sched.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared types, widths and LFSR step for the PUF challenge scheduler
package puf_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int NUM_W = 11;
  localparam logic [DATA_W-1:0] LFSR_POLY = 32'h8020_0003;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, EMIT} state_e;
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
    return x[0] ? (x >> 1) ^ LFSR_POLY : x >> 1;
  endfunction
endpackage

// File: rtl/puf_chal_sched_if.sv
// puf_chal_sched_if: valid/ready response stream carrying voted challenge words
interface puf_chal_sched_if;
  import puf_pkg::*;
  logic rsp_valid, rsp_ready, rsp_timeout;
  logic [ADDR_W-1:0] rsp_index;
  logic [DATA_W-1:0] rsp_word, rsp_stable;
  modport master(output rsp_valid, rsp_index, rsp_word, rsp_stable, rsp_timeout, input rsp_ready);
  modport slave(input rsp_valid, rsp_index, rsp_word, rsp_stable, rsp_timeout, output rsp_ready);
endinterface

// File: rtl/puf_vote_acc.sv
// puf_vote_acc: per-bit ones counters with majority and all-agree outputs
module puf_vote_acc import puf_pkg::*; #(
  parameter int REPEATS = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              acc,
  input  logic [DATA_W-1:0] bits,
  output logic [DATA_W-1:0] maj,
  output logic [DATA_W-1:0] stb
);
  logic [DATA_W-1:0][7:0] ones_q, ones_d;
  // clear wins over accumulate; votes are derived from the held counts
  always_comb begin
    ones_d = ones_q;
    maj = '0;
    stb = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ones_d[i] = clr ? 8'd0 : acc ? ones_q[i] + 8'(bits[i]) : ones_q[i];
      maj[i] = ones_q[i] > 8'(REPEATS / 2);
      stb[i] = ones_q[i] == 8'd0 || ones_q[i] == 8'(REPEATS);
    end
  end
  // counter register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ones_q <= '0;
    else ones_q <= ones_d;
endmodule

// File: rtl/puf_chal_sched.sv
// puf_chal_sched: walks challenges into rwc_ctrl, votes repeated trials, streams results
module puf_chal_sched import puf_pkg::*; #(
  parameter int REPEATS = 7,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] seed,
  input  logic [NUM_W-1:0]  num_challenges,
  output logic              gen_enable,
  output logic [ADDR_W-1:0] cha_addr,
  output logic [DATA_W-1:0] cha_data,
  input  logic              available,
  input  logic [DATA_W-1:0] rsp_write,
  input  logic [DATA_W-1:0] rsp_clean,
  puf_chal_sched_if.master  rsp,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  logic gen_q, gen_d, valid_q, valid_d, done_q, done_d, to_q, to_d;
  logic [ADDR_W-1:0] addr_q, addr_d, idx_q, idx_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d, maj, stb;
  logic [NUM_W-1:0] num_q, num_d;
  logic [7:0] trial_q, trial_d;
  logic [15:0] tmr_q, tmr_d;
  logic clr, acc, last;
  assign last = {1'b0, idx_q} == num_q - 11'd1;
  puf_vote_acc #(.REPEATS(REPEATS)) u_vote (
    .clk(clk), .resetn(resetn), .clr(clr), .acc(acc),
    .bits(rsp_write ^ rsp_clean), .maj(maj), .stb(stb)
  );
  assign gen_enable = gen_q;
  assign cha_addr = addr_q;
  assign cha_data = lfsr_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign rsp.rsp_valid = valid_q;
  assign rsp.rsp_index = idx_q;
  assign rsp.rsp_timeout = valid_q & to_q;
  assign rsp.rsp_word = valid_q && !to_q ? maj : '0;
  assign rsp.rsp_stable = valid_q && !to_q ? stb : '0;
  // next-state: abort overrides everything; one timer serves both timeout and gap
  always_comb begin
    state_d = state_q;
    gen_d = gen_q;
    valid_d = valid_q;
    done_d = 1'b0;
    to_d = to_q;
    addr_d = addr_q;
    idx_d = idx_q;
    lfsr_d = lfsr_q;
    num_d = num_q;
    trial_d = trial_q;
    tmr_d = tmr_q;
    clr = 1'b0;
    acc = 1'b0;
    if (abort) begin
      state_d = IDLE;
      gen_d = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_d = base_addr;
          lfsr_d = seed == '0 ? 32'h1 : seed;
          num_d = num_challenges;
          idx_d = '0;
          trial_d = '0;
          to_d = 1'b0;
          clr = 1'b1;
          if (num_challenges == '0) done_d = 1'b1;
          else state_d = ISSUE;
        end
        ISSUE: begin
          gen_d = 1'b1;
          tmr_d = '0;
          state_d = WAIT;
        end
        WAIT: if (available) begin
          acc = 1'b1;
          gen_d = 1'b0;
          tmr_d = '0;
          trial_d = trial_q + 8'd1;
          state_d = trial_q == 8'(REPEATS - 1) ? EMIT : GAP;
        end else if (tmr_q == 16'(TIMEOUT - 1)) begin
          gen_d = 1'b0;
          to_d = 1'b1;
          state_d = EMIT;
        end else tmr_d = tmr_q + 16'd1;
        GAP: begin
          tmr_d = tmr_q == 16'(GAP_CYCLES - 1) ? '0 : tmr_q + 16'd1;
          state_d = tmr_q == 16'(GAP_CYCLES - 1) ? ISSUE : GAP;
        end
        EMIT: if (valid_q && rsp.rsp_ready) begin
          valid_d = 1'b0;
          if (last) begin
            state_d = IDLE;
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
            addr_d = addr_q + 10'd1;
            lfsr_d = lfsr_next(lfsr_q);
            idx_d = idx_q + 10'd1;
            trial_d = '0;
            to_d = 1'b0;
            clr = 1'b1;
          end
        end else valid_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      gen_q <= 1'b0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      to_q <= 1'b0;
      addr_q <= '0;
      idx_q <= '0;
      lfsr_q <= 32'h1;
      num_q <= '0;
      trial_q <= '0;
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      gen_q <= gen_d;
      valid_q <= valid_d;
      done_q <= done_d;
      to_q <= to_d;
      addr_q <= addr_d;
      idx_q <= idx_d;
      lfsr_q <= lfsr_d;
      num_q <= num_d;
      trial_q <= trial_d;
      tmr_q <= tmr_d;
    end
endmodule

// File: tb/tb_puf_chal_sched.sv
// tb_puf_chal_sched: randomized rwc_ctrl responder and vote model around the scheduler
module tb_puf_chal_sched;
  localparam int REP = 7, GAP = 4, TO = 64;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, available = 1'b0;
  logic gen_enable, busy, done;
  logic [9:0] base_addr = '0, cha_addr;
  logic [31:0] seed = '0, cha_data, rsp_write = '0, rsp_clean = '0;
  logic [10:0] num_challenges = '0;
  puf_chal_sched_if rsp();
  puf_chal_sched #(.REPEATS(REP), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .base_addr(base_addr), .seed(seed), .num_challenges(num_challenges),
    .gen_enable(gen_enable), .cha_addr(cha_addr), .cha_data(cha_data),
    .available(available), .rsp_write(rsp_write), .rsp_clean(rsp_clean),
    .rsp(rsp), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int mode = 0, trial_n = 0, ncyc = 0, avail_n = -10, rise_n = 0, valid_at = -1;
  bit chk_gap = 0;
  logic gen_prev = 1'b0;
  logic [31:0] fix_raw = '0, script[REP];
  logic [31:0] trials[$], tdata[$];
  logic [9:0] taddr[$];
  logic [31:0] last_word, last_stable, d1;
  logic [9:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? (x >> 1) ^ 32'h8020_0003 : x >> 1;
  endfunction

  // rwc_ctrl stand-in: answers each enable after a random delay and logs the raw trial bits
  initial begin
    logic [31:0] raw, msk;
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (ncyc == avail_n + 1) chk("gen_drop", gen_enable, 0);
      if (ncyc == valid_at) chk("valid_lat", rsp.rsp_valid, 1);
      if (gen_enable && !gen_prev) begin
        rise_n = ncyc;
        if (chk_gap) chk("gap_lat", ncyc - avail_n, GAP + 2);
        chk_gap = 0;
      end
      if (!gen_enable && gen_prev && mode == 3 && resetn) chk("to_len", ncyc - rise_n, TO);
      gen_prev = gen_enable;
      available = 1'b0;
      if (gen_enable && mode != 3) begin
        if (dly == 0) begin
          raw = mode == 0 ? fix_raw : mode == 2 ? script[trial_n % REP] : $urandom;
          msk = $urandom;
          rsp_write = raw ^ msk;
          rsp_clean = msk;
          available = 1'b1;
          trials.push_back(raw);
          taddr.push_back(cha_addr);
          tdata.push_back(cha_data);
          trial_n++;
          avail_n = ncyc;
          if (trial_n % REP == 0) valid_at = ncyc + 2;
          else chk_gap = 1;
          dly = $urandom_range(0, 3);
        end else dly--;
      end else if (mode == 1 && $urandom_range(0, 7) == 0) begin
        rsp_write = $urandom;
        rsp_clean = $urandom;
        available = 1'b1;
      end
    end
  end

  task automatic run_seq(input logic [9:0] base, input logic [31:0] sd, input int num, input int rp);
    logic [9:0] ea, hi;
    logic [31:0] ed, hw, hs, w, s;
    logic ht;
    bit stall, xfer, pend, fin;
    int k, cyc, ns, ones;
    trials.delete(); taddr.delete(); tdata.delete();
    trial_n = 0; chk_gap = 0; valid_at = -1;
    ea = base;
    ed = sd == 0 ? 32'h1 : sd;
    @(negedge clk);
    base_addr = base; seed = sd; num_challenges = 11'(num); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (num == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      repeat (5) begin
        @(negedge clk);
        chk("zero_gen", gen_enable, 0);
      end
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_gen0", gen_enable, 0);
    chk("start_addr", cha_addr, base);
    chk("start_data", cha_data, ed);
    @(negedge clk);
    chk("start_gen1", gen_enable, 1);
    k = 0; cyc = 0; ns = 0; stall = 0; xfer = 0; pend = 0; fin = 0;
    hw = '0; hs = '0; hi = '0; ht = 1'b0;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        fin = 1;
      end else begin
        if (done) chk("done_early", done, 0);
        if (stall && rsp.rsp_valid) begin
          chk("hold_word", rsp.rsp_word, hw);
          chk("hold_stable", rsp.rsp_stable, hs);
          chk("hold_index", rsp.rsp_index, hi);
          chk("hold_to", rsp.rsp_timeout, ht);
        end
        if (xfer) chk("valid_drop", rsp.rsp_valid, 0);
        rsp.rsp_ready = rp < 0 ? !(rsp.rsp_valid && ns < 10) : $urandom_range(0, 99) < rp;
        if (rsp.rsp_valid && !rsp.rsp_ready) ns++;
        start = busy && !(rsp.rsp_valid && rsp.rsp_ready) && $urandom_range(0, 15) == 0;
        if (start) begin
          base_addr = $urandom; seed = $urandom; num_challenges = $urandom;
        end
        stall = rsp.rsp_valid && !rsp.rsp_ready;
        xfer = rsp.rsp_valid && rsp.rsp_ready;
        hw = rsp.rsp_word; hs = rsp.rsp_stable; hi = rsp.rsp_index; ht = rsp.rsp_timeout;
        if (xfer) begin
          ns = 0;
          w = '0; s = '0;
          if (mode != 3) begin
            chk("trial_cnt", trials.size(), REP);
            if (trials.size() >= REP) begin
              for (int b = 0; b < 32; b++) begin
                ones = 0;
                for (int j = 0; j < REP; j++) ones += int'(trials[j][b]);
                w[b] = ones > REP / 2;
                s[b] = ones == 0 || ones == REP;
              end
              for (int j = 0; j < REP; j++) begin
                chk("trial_addr", taddr[j], ea);
                chk("trial_data", tdata[j], ed);
              end
              repeat (REP) begin
                void'(trials.pop_front()); void'(taddr.pop_front()); void'(tdata.pop_front());
              end
            end
          end
          chk("index", rsp.rsp_index, k);
          chk("word", rsp.rsp_word, w);
          chk("stable", rsp.rsp_stable, s);
          chk("timeout", rsp.rsp_timeout, mode == 3);
          chk("cha_addr", cha_addr, ea);
          chk("cha_data", cha_data, ed);
          if (k == 1) d1 = cha_data;
          last_word = rsp.rsp_word; last_stable = rsp.rsp_stable; last_addr = cha_addr;
          if (k == num - 1) pend = 1;
          k++;
          ea = ea + 10'd1;
          ed = lfsr_step(ed);
        end
      end
    end
    start = 1'b0;
    rsp.rsp_ready = 1'b0;
    chk("run_done", fin, 1);
    chk("xfers", k, num);
  endtask

  task automatic wait_gen(input logic v, output bit ok);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = gen_enable == v;
    end
  endtask

  initial begin
    bit ok;
    int nd;
    rsp.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gen", gen_enable, 0);
    chk("rst_valid", rsp.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", cha_addr, 0);
    chk("rst_word", rsp.rsp_word, 0);
    chk("rst_stable", rsp.rsp_stable, 0);
    chk("rst_to", rsp.rsp_timeout, 0);
    chk("rst_index", rsp.rsp_index, 0);
    resetn = 1'b1;

    mode = 0; fix_raw = 32'hA5A5_0F0F;
    run_seq(10'd5, 32'h1, 1, 100);
    chk("single_word", last_word, 32'hA5A5_0F0F);
    chk("single_stable", last_stable, 32'hFFFF_FFFF);
    chk("single_addr", last_addr, 5);

    mode = 2;
    for (int j = 0; j < REP; j++) begin
      script[j] = $urandom;
      script[j][0] = j < 3;
      script[j][1] = j < 4;
    end
    run_seq(10'd200, 32'h1234, 1, 100);
    chk("maj_word", last_word[1:0], 2'b10);
    chk("maj_stable", last_stable[1:0], 2'b00);

    mode = 1;
    run_seq(10'd1022, 32'h1, 3, 70);
    chk("sweep_d1", d1, 32'h8020_0003);
    chk("sweep_wrap", last_addr, 0);
    run_seq(10'd300, 32'h0, 2, 50);

    mode = 3;
    run_seq(10'd100, 32'h9, 2, 80);

    mode = 1;
    run_seq(10'd50, 32'd77, 2, -1);

    mode = 0; fix_raw = $urandom;
    @(negedge clk);
    base_addr = 10'd7; seed = 32'h3; num_challenges = 11'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_gen(1'b1, ok);
    chk("abort_rise", ok, 1);
    wait_gen(1'b0, ok);
    chk("abort_fall", ok, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_gen", gen_enable, 0);
    chk("abort_valid", rsp.rsp_valid, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("abort_nodone", nd, 0);

    run_seq(10'd0, 32'd5, 0, 100);

    mode = 3;
    @(negedge clk);
    base_addr = 10'd9; seed = 32'h5; num_challenges = 11'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_gen(1'b1, ok);
    chk("areset_rise", ok, 1);
    #2 resetn = 1'b0;
    #1;
    chk("areset_gen", gen_enable, 0);
    chk("areset_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    mode = 1;
    run_seq(10'($urandom), $urandom, 4, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
